// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sizes, FSM encoding, S-box table and byte-order helpers.
package aes_pkg;

    localparam int AES_ROUNDS = 10;
    localparam int AES_BLK_W  = 128;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } aes_fsm_e;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    // Byte i of the block sits in column i/4, row i%4; ShiftRows pulls
    // row r from column (c + r) mod 4.
    function automatic int shift_rows_src(input int i);
        return 4*(((i / 4) + (i % 4)) % 4) + (i % 4);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One AES round stage: SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [AES_BLK_W-1:0] round_key,
    input  logic                 last,
    output logic [AES_BLK_W-1:0] state_out
);

    logic [AES_BLK_W-1:0] sub_b;
    logic [AES_BLK_W-1:0] shift_b;
    logic [AES_BLK_W-1:0] mix_b;

    for (genvar i = 0; i < 16; i++) begin : g_byte
        sbox u_sbox (
            .in_byte  (state_in[127-8*i -: 8]),
            .out_byte (sub_b[127-8*i -: 8])
        );
        assign shift_b[127-8*i -: 8] = sub_b[127-8*shift_rows_src(i) -: 8];
    end

    mix_columns u_mix (
        .state_in  (shift_b),
        .state_out (mix_b)
    );

    assign state_out = (last ? shift_b : mix_b) ^ round_key;

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: returns round key 'round' (0..10) for the given cipher key.
module key_expansion
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] key_in,
    input  logic [3:0]           round,
    output logic [AES_BLK_W-1:0] round_key
);

    // Full schedule expanded combinationally, then one 128-bit slice picked out.
    always_comb begin
        logic [31:0] w [0:4*AES_ROUNDS+3];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          idx;
        rcon      = 8'h01;
        t         = '0;
        idx       = 4 * int'(round);
        round_key = '0;
        for (int i = 0; i < 4; i++) begin
            w[i] = key_in[127-32*i -: 32];
        end
        for (int i = 4; i < 4*AES_ROUNDS+4; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_byte(t[23:16]), sbox_byte(t[15:8]),
                     sbox_byte(t[7:0]),   sbox_byte(t[31:24])} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        if (int'(round) <= AES_ROUNDS) begin
            round_key = {w[idx], w[idx+1], w[idx+2], w[idx+3]};
        end
    end

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns on a full 128-bit state, column by column.
module mix_columns
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    output logic [AES_BLK_W-1:0] state_out
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign state_out[127-32*c -: 32] = mix_col(state_in[127-32*c -: 32]);
    end

endmodule

// File: rtl/sbox.sv
// AES forward S-box, one byte.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_byte(in_byte);

endmodule

// File: rtl/aes_core_iter.sv
// Iterative AES-128 encryptor with UNROLL rounds per clock and valid/ready on both sides.
//
// state  | meaning
// S_IDLE | waiting for a block, in_ready high
// S_RUN  | applying UNROLL rounds per clock
// S_DONE | holding ciphertext/out_tag until out_ready
module aes_core_iter
    import aes_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int TAG_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] plaintext,
    input  logic [AES_BLK_W-1:0] key,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] ciphertext,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_core_iter: UNROLL must be 1, 2, 5 or 10");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_core_iter: TAG_W must be at least 1");
    end

    aes_fsm_e             fsm_q, fsm_d;
    logic [AES_BLK_W-1:0] state_reg_q, state_reg_d;
    logic [AES_BLK_W-1:0] key_reg_q, key_reg_d;
    logic [AES_BLK_W-1:0] ciphertext_q, ciphertext_d;
    logic [TAG_W-1:0]     tag_reg_q, tag_reg_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic [3:0]           round_ctr_q, round_ctr_d;

    logic [UNROLL:0][AES_BLK_W-1:0] chain;
    logic                           last_batch;

    assign chain[0]   = state_reg_q;
    assign last_batch = (round_ctr_q + 4'(UNROLL - 1)) == 4'(AES_ROUNDS);

    for (genvar g = 0; g < UNROLL; g++) begin : g_stage
        logic [3:0]           rnd;
        logic [AES_BLK_W-1:0] rk;
        assign rnd = round_ctr_q + 4'(g);
        key_expansion u_kexp (
            .key_in    (key_reg_q),
            .round     (rnd),
            .round_key (rk)
        );
        aes_round u_round (
            .state_in  (chain[g]),
            .round_key (rk),
            .last      (rnd == 4'(AES_ROUNDS)),
            .state_out (chain[g+1])
        );
    end

    assign in_ready   = (fsm_q == S_IDLE);
    assign out_valid  = (fsm_q == S_DONE);
    assign busy       = (fsm_q == S_RUN) || (fsm_q == S_DONE);
    assign ciphertext = ciphertext_q;
    assign out_tag    = out_tag_q;

    // Next-state and datapath load decisions; clear overrides every handshake.
    always_comb begin
        fsm_d        = fsm_q;
        state_reg_d  = state_reg_q;
        key_reg_d    = key_reg_q;
        tag_reg_d    = tag_reg_q;
        round_ctr_d  = round_ctr_q;
        ciphertext_d = ciphertext_q;
        out_tag_d    = out_tag_q;
        if (clear) begin
            fsm_d       = S_IDLE;
            round_ctr_d = 4'd0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_reg_d = plaintext ^ key;
                        key_reg_d   = key;
                        tag_reg_d   = in_tag;
                        round_ctr_d = 4'd1;
                        fsm_d       = S_RUN;
                    end
                end
                S_RUN: begin
                    state_reg_d = chain[UNROLL];
                    round_ctr_d = round_ctr_q + 4'(UNROLL);
                    if (last_batch) begin
                        ciphertext_d = chain[UNROLL];
                        out_tag_d    = tag_reg_q;
                        fsm_d        = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm_d = S_IDLE;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q        <= S_IDLE;
            state_reg_q  <= '0;
            key_reg_q    <= '0;
            tag_reg_q    <= '0;
            round_ctr_q  <= 4'd0;
            ciphertext_q <= '0;
            out_tag_q    <= '0;
        end else begin
            fsm_q        <= fsm_d;
            state_reg_q  <= state_reg_d;
            key_reg_q    <= key_reg_d;
            tag_reg_q    <= tag_reg_d;
            round_ctr_q  <= round_ctr_d;
            ciphertext_q <= ciphertext_d;
            out_tag_q    <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_aes_core_iter.sv
// Bench for aes_core_iter: four instances (UNROLL 1, 2, 5, 10) checked against FIPS-197
// vectors and a byte-array AES model built from GF(2^8) arithmetic.
module tb_aes_core_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n, clear, out_ready;
    logic [3:0]   iv;
    logic [127:0] plaintext, key;
    logic [7:0]   in_tag;
    logic [3:0]   ir, ov, bz;
    logic [127:0] ct [4];
    logic [7:0]   ot [4];
    logic [127:0] last_ct [4];
    logic [7:0]   last_tag [4];
    logic [7:0]   sb [256];
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes_core_iter #(
            .UNROLL (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10),
            .TAG_W  (8)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .plaintext  (plaintext),
            .key        (key),
            .in_tag     (in_tag),
            .out_valid  (ov[g]),
            .out_ready  (out_ready),
            .ciphertext (ct[g]),
            .out_tag    (ot[g]),
            .busy       (bz[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
            end
            x = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[a] = x;
        end
    endtask

    function automatic logic [7:0] mc_coef(input int row, input int col);
        if (col == row) return 8'h02;
        if (col == (row + 1) % 4) return 8'h03;
        return 8'h01;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [176];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, b0;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                b0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[b0];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++) begin
                        t[4*c+row] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            t[4*c+row] ^= gmul(mc_coef(row, j), s[4*c+j]);
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus ----------------
    task automatic run_block(input int k, input logic [127:0] pt, input logic [127:0] kk,
                             input logic [7:0] tag, input logic [127:0] exp,
                             input bit scramble, input int hold);
        int lat, n;
        n = (k == 0) ? 10 : (k == 1) ? 5 : (k == 2) ? 2 : 1;
        plaintext = pt; key = kk; in_tag = tag; out_ready = 1'b0;
        chk("in_ready_idle", 128'(ir[k]), 1);
        iv[k] = 1'b1;
        tick();
        iv[k] = 1'b0;
        chk("busy_after_accept", 128'(bz[k]), 1);
        lat = 0;
        while (!ov[k] && lat < 40) begin
            if (scramble) begin
                plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
                key       = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_tag    = 8'($urandom());
            end
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'(n));
        chk("ciphertext", ct[k], exp);
        chk("out_tag", 128'(ot[k]), 128'(tag));
        chk("in_ready_done", 128'(ir[k]), 0);
        for (int i = 0; i < hold; i++) begin
            if (scramble) key = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            chk("hold_ct", ct[k], exp);
            chk("hold_tag", 128'(ot[k]), 128'(tag));
            chk("hold_in_ready", 128'(ir[k]), 0);
            chk("hold_out_valid", 128'(ov[k]), 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", 128'(ov[k]), 0);
        chk("idle_after_hs", 128'(ir[k]), 1);
        last_ct[k]  = exp;
        last_tag[k] = tag;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rpt, rkey;
        logic [7:0]   rtag;
        bit           seen;
        rst_n = 1'b0; clear = 1'b0; iv = 4'h0; out_ready = 1'b0;
        plaintext = '0; key = '0; in_tag = '0;
        build_sbox();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_in_ready", 128'(ir[k]), 1);
            chk("rst_out_valid", 128'(ov[k]), 0);
            chk("rst_busy", 128'(bz[k]), 0);
            chk("rst_ct", ct[k], 0);
            chk("rst_tag", 128'(ot[k]), 0);
            last_ct[k] = '0; last_tag[k] = '0;
        end

        // FIPS-197 C.1 at UNROLL=1, Appendix B at UNROLL=2/5/10
        run_block(0, C1_PT, C1_KEY, 8'h5a, C1_CT, 1'b0, 0);
        for (int k = 1; k < 4; k++) run_block(k, B_PT, B_KEY, 8'(8'h30 + k), B_CT, 1'b0, 0);

        // back-pressure
        run_block(0, C1_PT, C1_KEY, 8'hc3, C1_CT, 1'b0, 20);

        // input isolation
        run_block(0, C1_PT, C1_KEY, 8'h5a, C1_CT, 1'b1, 2);
        run_block(3, C1_PT, C1_KEY, 8'h11, C1_CT, 1'b1, 1);

        // clear in IDLE with in_valid: no accept
        clear = 1'b1; iv[1] = 1'b1;
        tick();
        clear = 1'b0; iv[1] = 1'b0;
        chk("clear_idle_busy", 128'(bz[1]), 0);
        chk("clear_idle_ready", 128'(ir[1]), 1);

        // abort at RUN cycle 4
        plaintext = C1_PT; key = C1_KEY; in_tag = 8'h77; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (3) tick();
        clear = 1'b1; iv[0] = 1'b1;
        tick();
        clear = 1'b0; iv[0] = 1'b0;
        chk("abort_in_ready", 128'(ir[0]), 1);
        chk("abort_busy", 128'(bz[0]), 0);
        chk("abort_out_valid", 128'(ov[0]), 0);
        chk("abort_ct_kept", ct[0], last_ct[0]);
        chk("abort_tag_kept", 128'(ot[0]), 128'(last_tag[0]));
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (ov[0] || bz[0]) seen = 1'b1;
        end
        chk("abort_quiet", 128'(seen), 0);
        run_block(0, C1_PT, C1_KEY, 8'h5a, C1_CT, 1'b0, 0);

        // reset at RUN cycle 6
        plaintext = B_PT; key = B_KEY; in_tag = 8'h99; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rrst_out_valid", 128'(ov[0]), 0);
        chk("rrst_busy", 128'(bz[0]), 0);
        chk("rrst_ct", ct[0], 0);
        chk("rrst_tag", 128'(ot[0]), 0);
        chk("rrst_in_ready", 128'(ir[0]), 1);
        for (int k = 0; k < 4; k++) begin
            last_ct[k] = '0; last_tag[k] = '0;
        end
        run_block(0, C1_PT, C1_KEY, 8'h5a, C1_CT, 1'b0, 0);

        // random blocks against the model on every unroll factor
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 6; j++) begin
                rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
                rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
                rtag = 8'($urandom());
                run_block(k, rpt, rkey, rtag, aes_ref(rpt, rkey), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_core_iter.md
# aes_core_iter

Parametrised iterative AES-128 encryption engine, the next generation of the single-round-per-cycle core. It adds a valid/ready handshake on both sides, a configurable number of rounds unrolled per clock, and a user tag carried alongside each block. The engine sits between the block-cipher mode logic (ECB/CTR sequencer) and the plaintext/key source. It reuses the existing `sbox`, `mix_columns` and `key_expansion` leaf modules.

## Interface
- `UNROLL`, 1: rounds computed per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration error.
- `TAG_W`, 8: width of the sideband tag; minimum 1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `clear` in 1: synchronous abort; takes priority over all handshakes.
- `in_valid` in 1: plaintext, key and tag are presented.
- `in_ready` out 1: engine can accept a block.
- `plaintext` in 128: byte 0 is `[127:120]`.
- `key` in 128: AES-128 cipher key, same byte order.
- `in_tag` in TAG_W: opaque sideband.
- `out_valid` out 1: ciphertext is available.
- `out_ready` in 1: consumer accepts the ciphertext.
- `ciphertext` out 128: result.
- `out_tag` out TAG_W: tag of the block being output.
- `busy` out 1: high in states RUN and DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`:
    - load `state_reg` <= `plaintext ^ key` (round-0 AddRoundKey);
    - capture `key_reg` <= `key` and `tag_reg` <= `in_tag`;
    - set `round_ctr` <= 1;
    - go to RUN.
- RUN:
  - Apply rounds `round_ctr` .. `round_ctr+UNROLL-1` through a chain of `UNROLL` round stages.
  - Each stage uses `key_expansion(key_reg, r)`.
  - Each stage performs SubBytes → ShiftRows → MixColumns → AddRoundKey. When r==10 the stage skips MixColumns.
  - Update `round_ctr` += `UNROLL`.
  - When the rounds just applied include round 10:
    - load the final state into `ciphertext`;
    - load `tag_reg` into `out_tag`;
    - go to DONE.
- DONE:
  - `out_valid`=1.
  - `ciphertext` and `out_tag` stay stable until `out_valid & out_ready`, then go to IDLE.
  - `in_ready`=0 in RUN and DONE; there is no overlap of blocks.
- Round index width is 4 bits. It never exceeds 11, so there is no wrap.
- `key_reg` isolates the engine from the input: changes to `key` or `plaintext` after acceptance have no effect.
- `clear`=1 (with `rst_n`=1):
  - next state is IDLE;
  - `out_valid` drops the next cycle;
  - `round_ctr` is set to 0;
  - `ciphertext` and `out_tag` are retained;
  - `in_valid` in the same cycle is ignored (no accept).
- Reset (`rst_n`=0 at an edge), from any state including mid-RUN:
  - state goes to IDLE;
  - `out_valid`=0, `busy`=0;
  - `ciphertext`=0, `out_tag`=0, `state_reg`=0, `key_reg`=0, `round_ctr`=0.
- Reset values of outputs: `in_ready` is 1 (combinational from IDLE); `out_valid`, `busy`, `ciphertext` and `out_tag` are 0.

## Timing
- N = 10/UNROLL.
- Accept edge E0.
- RUN occupies edges E1..EN.
- `out_valid` is high from after edge EN.
- Latency, accept to `out_valid`: N cycles (10, 5, 2 or 1).
- With `out_ready` held high, the next accept is at EN+2. Minimum block period is N+2 cycles.
- `out_ready` low stalls DONE indefinitely with no data change.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `out_ready` or `in_valid` to any output.
- Critical path grows linearly with UNROLL: UNROLL × (sbox + mix_columns + xor) plus key_expansion. No timing constraint is imposed by this block.

## Structure
- Shared `aes_pkg` holds:
  - `AES_ROUNDS` = 10;
  - `AES_BLK_W` = 128;
  - the state enum (IDLE/RUN/DONE);
  - a byte-order helper for ShiftRows indexing.
- Sub-module `aes_round`, one round stage:
  - inputs: `state_in`, `round_key`, `last`;
  - output: `state_out`;
  - contents: 16 `sbox` instances, ShiftRows wiring, one `mix_columns`, and a final mux on `last`.
- Top level instantiates `UNROLL` × `aes_round` and `UNROLL` × `key_expansion` in a generate loop, plus the FSM and registers.

## Test plan
- FIPS-197 C.1, UNROLL=1:
  - key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, tag 0x5A;
  - → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with `out_tag` 0x5A, `out_valid` exactly 10 cycles after accept.
- FIPS-197 Appendix B, repeated for UNROLL = 2, 5 and 10:
  - key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734;
  - → 3925841d02dc09fbdc118597196a0b32 at latency 5, 2 and 1 respectively.
- Back-pressure:
  - hold `out_ready`=0 for 20 cycles after `out_valid`;
  - → `ciphertext` and `out_tag` stable and `in_ready`=0 throughout; one handshake on release; IDLE the next cycle.
- Input isolation:
  - change `key` and `plaintext` to random values every cycle after accept;
  - → result is still the C.1 vector.
- Abort:
  - assert `clear` at RUN cycle 4 together with `in_valid`=1;
  - → no accept; IDLE next cycle; no `out_valid`; a following C.1 block completes correctly.
- Reset mid-RUN:
  - `rst_n`=0 for one edge at RUN cycle 6;
  - → all outputs 0, `in_ready`=1 the next cycle; a subsequent block matches the golden vector.
